// File: rtl/change_dispenser.sv
// Change-return sequencer: pays out a captured amount in 10- and 5-unit coins,
// one coin per eject/acknowledge handshake, faulting on bad amounts or a silent hopper.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       coin_ack,
  input  logic       empty10,
  input  logic       empty5,
  output logic       coin10,
  output logic       coin5,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_WAIT_ACK,
    S_FINISH,
    S_FAULT
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] rem_q, rem_d;
  logic [7:0] timer_q, timer_d;
  logic       denom10_q, denom10_d;
  logic       coin10_q, coin10_d;
  logic       coin5_q, coin5_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    timer_d   = timer_q;
    denom10_d = denom10_q;

    unique case (state_q)
      S_IDLE, S_FAULT: begin
        if (start) begin
          rem_d   = amount;
          state_d = ((amount % 5'd5) == '0) ? S_SELECT : S_FAULT;
        end
      end
      S_SELECT: begin
        // Hopper flags are looked at afresh for every coin, so a request may mix denominations.
        if (rem_q == '0) begin
          state_d = S_FINISH;
        end else if (rem_q >= 5'd10 && !empty10) begin
          denom10_d = 1'b1;
          state_d   = S_EJECT;
        end else if (rem_q >= 5'd5 && !empty5) begin
          denom10_d = 1'b0;
          state_d   = S_EJECT;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_EJECT: begin
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (coin_ack) begin
          if (denom10_q && rem_q >= 5'd10) begin
            rem_d = rem_q - 5'd10;
          end else if (!denom10_q && rem_q >= 5'd5) begin
            rem_d = rem_q - 5'd5;
          end
          state_d = S_SELECT;
        end else if (timer_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they decode.
    coin10_d = (state_d == S_EJECT) && denom10_d;
    coin5_d  = (state_d == S_EJECT) && !denom10_d;
    busy_d   = (state_d == S_SELECT) || (state_d == S_EJECT) ||
               (state_d == S_WAIT_ACK) || (state_d == S_FINISH);
    done_d   = (state_d == S_FINISH);
    fault_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      timer_q   <= '0;
      denom10_q <= 1'b1;
      coin10_q  <= 1'b0;
      coin5_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      denom10_q <= denom10_d;
      coin10_q  <= coin10_d;
      coin5_q   <= coin5_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign coin10    = coin10_q;
  assign coin5     = coin5_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a reference payout model queues the
// expected coin/done/fault events with their cycle and owed amount.
module tb_change_dispenser;

  localparam int unsigned ACK_TIMEOUT = 8;

  logic       clock = 1'b0;
  logic       reset, start, coin_ack, empty10, empty5;
  logic [4:0] amount;
  logic       coin10, coin5, busy, done, fault;
  logic [4:0] remaining;

  change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .amount    (amount),
    .coin_ack  (coin_ack),
    .empty10   (empty10),
    .empty5    (empty5),
    .coin10    (coin10),
    .coin5     (coin5),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining)
  );

  always #5 clock = ~clock;

  // kind: 1 = coin10, 2 = coin5, 3 = done, 4 = fault rising
  typedef struct {
    int kind;
    int cyc;
    int rem;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  logic ack_en = 1'b0, ack_force = 1'b0, ack_pend = 1'b0, fault_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Hopper: acknowledges in the first WAIT_ACK cycle after an eject pulse.
  always @(negedge clock) begin
    coin_ack = (ack_en && ack_pend) || ack_force;
    ack_pend = coin10 || coin5;
  end

  always @(negedge clock) begin
    int kind;
    ev_t e;
    if (coin10 && coin5) chk("both_coins", 1, 0);
    kind = coin10 ? 1 : coin5 ? 2 : done ? 3 : (fault && !fault_prev) ? 4 : 0;
    fault_prev = fault;
    if (kind != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ev", kind, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_kind", kind, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_rem", int'(remaining), e.rem);
      end
    end
  end

  function automatic ev_t mk(input int k, input int c, input int r);
    ev_t e;
    e.kind = k; e.cyc = c; e.rem = r;
    return e;
  endfunction

  // Reference payout: SELECT at c0+1, each acked coin takes 3 cycles.
  task automatic push_model(input int c0, input int amt, input bit e10, input bit e5, input bit ack);
    int t = c0 + 1;
    int r = amt;
    if (amt % 5 != 0) begin
      exp_q.push_back(mk(4, t, amt));
      return;
    end
    forever begin
      int d;
      if (r == 0) begin exp_q.push_back(mk(3, t + 1, 0)); return; end
      if (r >= 10 && !e10) d = 10;
      else if (r >= 5 && !e5) d = 5;
      else begin exp_q.push_back(mk(4, t + 1, r)); return; end
      exp_q.push_back(mk(d == 10 ? 1 : 2, t + 1, r));
      if (!ack) begin
        exp_q.push_back(mk(4, t + 2 + int'(ACK_TIMEOUT), r));
        return;
      end
      r -= d;
      t += 3;
    end
  endtask

  task automatic do_start(input int amt, output int c0);
    @(negedge clock);
    c0 = cyc;
    start = 1'b1;
    amount = 5'(amt);
    @(negedge clock);
    start = 1'b0;
    amount = 5'($urandom_range(0, 31));
  endtask

  task automatic run(input int amt, input bit e10, input bit e5, input bit ack);
    int c0;
    empty10 = e10; empty5 = e5; ack_en = ack;
    @(negedge clock);
    c0 = cyc + 1;
    push_model(c0, amt, e10, e5, ack);
    do_start(amt, c0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; amount = '0; empty10 = 1'b0; empty5 = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_outs", {coin10, coin5, busy, done, fault}, 0);
    chk("rst_rem", int'(remaining), 0);

    run(0, 0, 0, 1);  drain();
    run(15, 0, 0, 1);
    repeat (2) @(negedge clock);
    chk("busy_mid", int'(busy), 1);
    drain();
    chk("rem_15", int'(remaining), 0);
    run(20, 1, 0, 1); drain();
    chk("rem_20", int'(remaining), 0);
    run(30, 0, 0, 1); drain();
    run(25, 0, 0, 1); drain();

    run(7, 0, 0, 1);  drain();
    chk("rem_7", int'(remaining), 7);
    chk("fault_7", int'(fault), 1);
    run(5, 0, 0, 1);
    chk("fault_clr", int'(fault), 0);
    drain();

    run(10, 0, 0, 0); drain();
    chk("rem_to", int'(remaining), 10);
    run(10, 1, 1, 1); drain();
    chk("busy_fault", int'(busy), 0);

    // Stray ack while idle must not touch anything.
    run(0, 0, 0, 1); drain();
    ack_force = 1'b1;
    repeat (2) @(negedge clock);
    ack_force = 1'b0;
    @(negedge clock);
    chk("idle_ack_rem", int'(remaining), 0);
    chk("idle_ack_busy", int'(busy), 0);

    // Start while busy is ignored.
    empty10 = 1'b0; empty5 = 1'b0; ack_en = 1'b1;
    @(negedge clock);
    push_model(cyc + 1, 15, 0, 0, 1);
    do_start(15, c0);
    @(negedge clock);
    start = 1'b1; amount = 5'd5;
    @(negedge clock);
    start = 1'b0;
    drain();

    // Reset in WAIT_ACK.
    ack_en = 1'b0;
    @(negedge clock);
    exp_q.push_back(mk(1, cyc + 3, 10));
    do_start(10, c0);
    while (cyc < c0 + 3) @(negedge clock);
    chk("in_wait_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("wrst_outs", {coin10, coin5, busy, done, fault}, 0);
    chk("wrst_rem", int'(remaining), 0);
    repeat (ACK_TIMEOUT + 4) @(negedge clock);
    chk("wrst_fault", int'(fault), 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
